// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ctrl_pkg
//  Description : Shared types, default widths and small unsigned helpers for
//                the PWM ramp controller and its period timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

  localparam int c_DEF_WIDTH  = 16;
  localparam int c_DEF_STEP_W = 8;
  localparam int c_DEF_HOLD_W = 8;

  // Helpers operate on a fixed wide operand; callers zero-extend into it.
  // This limits WIDTH to at most 32 bits.
  localparam int c_ARITH_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    RAMP      = 2'd2
  } state_t;

  // Unsigned minimum.
  function automatic logic [c_ARITH_W-1:0] min_u(input logic [c_ARITH_W-1:0] a,
                                                input logic [c_ARITH_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Unsigned absolute difference, one extra bit so it never wraps.
  function automatic logic [c_ARITH_W:0] absdiff(input logic [c_ARITH_W-1:0] a,
                                                input logic [c_ARITH_W-1:0] b);
    return (a > b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_ctrl_if
//  Description : Ramp-command handshake between the register file (master)
//                and the PWM ramp controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_ramp_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 8,
  parameter int HOLD_W = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_period;
  logic [WIDTH-1:0]  cmd_duty;
  logic [STEP_W-1:0] cmd_step;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (
    output cmd_valid, cmd_period, cmd_duty, cmd_step, cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_period, cmd_duty, cmd_step, cmd_hold,
    output cmd_ready
  );

endinterface
`default_nettype wire

// File: rtl/pwm_period_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_period_timer
//  Description : Free-running 0..period-1 counter mirroring the pwm block's
//                counter; flags the last cycle of every PWM period. A period
//                of 0 makes every cycle a boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_period_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] cnt,
  output logic             period_tick
);

  logic             r_run;
  logic [WIDTH-1:0] r_cnt;
  logic             w_last;

  // Last cycle of the period (or any cycle when the PWM is off).
  assign w_last      = (period == '0) || (r_cnt == (period - WIDTH'(1)));
  // Ticks are suppressed while in reset and on the first cycle after it,
  // so the tick output carries its reset value of 0.
  assign period_tick = r_run && w_last;
  assign cnt         = r_cnt;

  // Count up and wrap on the last cycle; held at 0 when the PWM is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_run <= 1'b1;
      r_cnt <= w_last ? '0 : (r_cnt + WIDTH'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_ctrl
//  Description : Owns pwm.period / pwm.duty_cycle. Accepts ramp commands,
//                commits the new period at a PWM boundary, then walks the
//                duty toward the (clamped) target one step every hold+1
//                periods. Abort freezes period and duty where they are.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH  = c_DEF_WIDTH,
  parameter int STEP_W = c_DEF_STEP_W,
  parameter int HOLD_W = c_DEF_HOLD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_ramp_ctrl_if.slave   cmd,
  input  logic             abort,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             period_tick,
  output logic             busy,
  output logic             done
);

  localparam int c_DW = WIDTH + 1;

  state_t            r_state;
  logic [WIDTH-1:0]  r_period;
  logic [WIDTH-1:0]  r_duty;
  logic [WIDTH-1:0]  r_np;
  logic [WIDTH-1:0]  r_tgt;
  logic [STEP_W-1:0] r_step;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic [WIDTH-1:0]  w_cnt;
  logic              w_tick;
  logic [WIDTH-1:0]  w_tgt_clamp;
  logic [WIDTH-1:0]  w_duty_clamp;
  logic [WIDTH:0]    w_diff;
  logic [WIDTH-1:0]  w_step_ext;
  logic              w_last_step;
  logic              w_up;

  pwm_period_timer #(
    .WIDTH (WIDTH)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .period      (r_period),
    .cnt         (w_cnt),
    .period_tick (w_tick)
  );

  // Target can never exceed the period it will run under.
  assign w_tgt_clamp  = WIDTH'(min_u(c_ARITH_W'(cmd.cmd_duty), c_ARITH_W'(cmd.cmd_period)));
  // Current duty is pulled down if the new period is shorter.
  assign w_duty_clamp = WIDTH'(min_u(c_ARITH_W'(r_duty), c_ARITH_W'(r_np)));
  assign w_diff       = c_DW'(absdiff(c_ARITH_W'(r_tgt), c_ARITH_W'(r_duty)));
  assign w_step_ext   = WIDTH'(r_step);
  // Final step: jump mode, or the remaining distance fits in one step.
  assign w_last_step  = (r_step == '0) || (w_diff <= {1'b0, w_step_ext});
  assign w_up         = (r_tgt > r_duty);

  assign cmd.cmd_ready = r_ready;
  assign period        = r_period;
  assign duty_cycle    = r_duty;
  assign period_tick   = w_tick;
  assign busy          = r_busy;
  assign done          = r_done;

  // Command sequencing, period commit and duty stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_period   <= '0;
      r_duty     <= '0;
      r_np       <= '0;
      r_tgt      <= '0;
      r_step     <= '0;
      r_hold     <= '0;
      r_hold_cnt <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (cmd.cmd_valid && r_ready) begin
            r_np    <= cmd.cmd_period;
            r_tgt   <= w_tgt_clamp;
            r_step  <= cmd.cmd_step;
            r_hold  <= cmd.cmd_hold;
            r_state <= WAIT_EDGE;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        WAIT_EDGE: begin
          if (w_tick) begin
            // The period commit happens even when aborting on this edge.
            r_period   <= r_np;
            r_duty     <= w_duty_clamp;
            r_hold_cnt <= '0;
            if (abort) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= RAMP;
            end
          end else if (abort) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        RAMP: begin
          if (abort) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            if (r_hold_cnt != r_hold) begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end else if (w_last_step) begin
              r_duty  <= r_tgt;
              r_done  <= 1'b1;
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_duty     <= w_up ? (r_duty + w_step_ext) : (r_duty - w_step_ext);
              r_hold_cnt <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_ramp_ctrl
//  Description : Directed bench for pwm_ramp_ctrl with a closed-form
//                reference model compared every cycle, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic [15:0] period;
  logic [15:0] duty_cycle;
  logic        period_tick;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  pwm_ramp_ctrl_if #(.WIDTH(16), .STEP_W(8), .HOLD_W(8)) cmd_if ();

  pwm_ramp_ctrl #(.WIDTH(16), .STEP_W(8), .HOLD_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd_if),
    .abort       (abort),
    .period      (period),
    .duty_cycle  (duty_cycle),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Timing is expressed as the age (cycles) since the last period commit and
  // the number of boundaries seen since that commit; the duty after n due
  // steps is start moved n*step toward target, saturating at target.
  int m_state  = 0;   // 0 idle, 1 waiting for boundary, 2 ramping
  int m_period = 0;
  int m_duty   = 0;
  int m_start  = 0;
  int m_np     = 0;
  int m_tgt    = 0;
  int m_step   = 0;
  int m_hold   = 0;
  int m_age    = 0;
  int m_nb     = 0;
  int m_first  = 0;
  int m_done   = 0;
  int m_n, m_dist;
  bit m_t;

  function automatic bit model_tick();
    if (m_first == 0) return 1'b0;
    if (m_period == 0) return 1'b1;
    return (m_age % m_period) == (m_period - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_period = 0; m_duty = 0; m_start = 0; m_np = 0;
      m_tgt = 0; m_step = 0; m_hold = 0; m_age = 0; m_nb = 0;
      m_first = 0; m_done = 0;
    end else begin
      m_t    = model_tick();
      m_done = 0;
      case (m_state)
        0: if (cmd_if.cmd_valid) begin
          m_np    = int'(cmd_if.cmd_period);
          m_tgt   = (int'(cmd_if.cmd_duty) < m_np) ? int'(cmd_if.cmd_duty) : m_np;
          m_step  = int'(cmd_if.cmd_step);
          m_hold  = int'(cmd_if.cmd_hold);
          m_state = 1;
        end
        1: if (m_t) begin
          m_period = m_np;
          if (m_duty > m_np) m_duty = m_np;
          m_start  = m_duty;
          m_nb     = 0;
          m_age    = -1;
          m_state  = abort ? 0 : 2;
        end else if (abort) begin
          m_state = 0;
        end
        2: if (abort) begin
          m_state = 0;
        end else if (m_t) begin
          m_nb++;
          if (m_nb % (m_hold + 1) == 0) begin
            m_n    = m_nb / (m_hold + 1);
            m_dist = (m_tgt > m_start) ? (m_tgt - m_start) : (m_start - m_tgt);
            if (m_step == 0 || m_dist <= m_n * m_step) begin
              m_duty  = m_tgt;
              m_done  = 1;
              m_state = 0;
            end else begin
              m_duty = (m_tgt > m_start) ? (m_start + m_n * m_step) : (m_start - m_n * m_step);
            end
          end
        end
        default: m_state = 0;
      endcase
      m_age++;
      if (m_first < 2) m_first++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("period",      int'(period),           m_period);
      chk("duty_cycle",  int'(duty_cycle),       m_duty);
      chk("period_tick", int'(period_tick),      int'(model_tick()));
      chk("busy",        int'(busy),             int'(m_state != 0));
      chk("cmd_ready",   int'(cmd_if.cmd_ready), int'(m_state == 0));
      chk("done",        int'(done),             m_done);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int p, input int d, input int s, input int h);
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_period = 16'(p);
    cmd_if.cmd_duty   = 16'(d);
    cmd_if.cmd_step   = 8'(s);
    cmd_if.cmd_hold   = 8'(h);
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b0;
    chk("accept_busy", int'(busy), 1);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  int cyc;
  int vals[8];
  int tms[8];
  int nrec, ndone, prev;

  initial begin
    rst_n = 1'b1; abort = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_period = '0; cmd_if.cmd_duty = '0;
    cmd_if.cmd_step = '0; cmd_if.cmd_hold = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_period", int'(period), 0);
    chk("rst_duty",   int'(duty_cycle), 0);
    chk("rst_ready",  int'(cmd_if.cmd_ready), 1);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_done",   int'(done), 0);
    chk("rst_tick",   int'(period_tick), 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);

    // Jump from reset: commit on next cycle, done 10 cycles later
    send(10, 5, 0, 0);
    @(negedge clk);
    chk("t2_period", int'(period), 10);
    chk("t2_duty0",  int'(duty_cycle), 0);
    wait_done(40, cyc);
    chk("t2_latency", cyc, 10);
    chk("t2_duty",    int'(duty_cycle), 5);
    chk("t2_ready",   int'(cmd_if.cmd_ready), 1);

    // Bring duty to 0, then ramp 0->9 step 4 hold 1
    send(10, 0, 0, 0);
    wait_done(40, cyc);
    send(10, 9, 4, 1);
    prev = int'(duty_cycle); nrec = 0; ndone = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (int'(duty_cycle) != prev) begin
        if (nrec < 8) begin vals[nrec] = int'(duty_cycle); tms[nrec] = i; end
        nrec++;
        prev = int'(duty_cycle);
      end
      if (done) begin
        ndone++;
        chk("t3_done_at_9", int'(duty_cycle), 9);
      end
    end
    chk("t3_nchanges", nrec, 3);
    chk("t3_v0", vals[0], 4);
    chk("t3_v1", vals[1], 8);
    chk("t3_v2", vals[2], 9);
    chk("t3_gap01", tms[1] - tms[0], 20);
    chk("t3_gap12", tms[2] - tms[1], 20);
    chk("t3_ndone", ndone, 1);

    // Shrinking period clamps duty and target
    send(100, 80, 0, 0);
    wait_done(300, cyc);
    chk("t4_duty80", int'(duty_cycle), 80);
    send(50, 70, 0, 0);
    cyc = 0;
    while (int'(period) == 100 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("t4_period", int'(period), 50);
    chk("t4_clamp",  int'(duty_cycle), 50);
    wait_done(200, cyc);
    chk("t4_final", int'(duty_cycle), 50);

    // Ramp 0->200 step 10, abort after the third step
    send(250, 0, 0, 0);
    wait_done(400, cyc);
    send(250, 200, 10, 0);
    cyc = 0;
    while (int'(duty_cycle) != 30 && cyc < 1500) begin @(negedge clk); cyc++; end
    chk("t5_reach30", int'(duty_cycle), 30);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy",  int'(busy), 0);
    chk("t5_ready", int'(cmd_if.cmd_ready), 1);
    chk("t5_duty",  int'(duty_cycle), 30);
    chk("t5_done",  int'(done), 0);
    // New command right away; target equals current duty
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_period = 16'd250; cmd_if.cmd_duty = 16'd30;
    cmd_if.cmd_step = 8'd0; cmd_if.cmd_hold = 8'd0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    chk("t5_reaccept", int'(busy), 1);
    wait_done(600, cyc);
    chk("t5_final", int'(duty_cycle), 30);

    // Valid held while busy; fields changed after acceptance
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_period = 16'd40; cmd_if.cmd_duty = 16'd20;
    cmd_if.cmd_step = 8'd5; cmd_if.cmd_hold = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_ready_low", int'(cmd_if.cmd_ready), 0);
    end
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_duty = 16'd3; cmd_if.cmd_period = 16'd7;
    wait_done(600, cyc);
    chk("t6_duty",   int'(duty_cycle), 20);
    chk("t6_period", int'(period), 40);

    // Asynchronous reset in the middle of a ramp
    send(40, 0, 1, 3);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_period", int'(period), 0);
    chk("t7_duty",   int'(duty_cycle), 0);
    chk("t7_busy",   int'(busy), 0);
    chk("t7_ready",  int'(cmd_if.cmd_ready), 1);
    chk("t7_done",   int'(done), 0);
    chk("t7_tick",   int'(period_tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequencer that owns the `period` and `duty_cycle` inputs of the team's `pwm` block.
- Accepts ramp commands (new period, target duty, step, hold) over a valid/ready handshake.
- Commits the new period glitch-free at a PWM period boundary, then ramps duty toward target one step per (hold+1) periods.
- Sits between the bus-side register file and `pwm`; runs its own period timer that matches pwm's 0..period-1 counter.

Parameters:
- WIDTH, 16, width of period and duty values.
- STEP_W, 8, width of duty step size.
- HOLD_W, 8, width of per-step hold count (periods).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_period  in  WIDTH  new PWM period in clk cycles.
- cmd_duty  in  WIDTH  target duty in clk cycles.
- cmd_step  in  STEP_W  duty increment per step; 0 means jump to target.
- cmd_hold  in  HOLD_W  extra periods between steps.
- abort  in  1  stop ramp, freeze duty.
- period  out  WIDTH  drives pwm.period.
- duty_cycle  out  WIDTH  drives pwm.duty_cycle.
- period_tick  out  1  one-cycle pulse on the last cycle of each PWM period.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when duty reaches target.

Behaviour:
- Reset values (async, immediate, also mid-ramp): period=0, duty_cycle=0, cnt=0, hold_cnt=0, state=IDLE, cmd_ready=1, busy=0, done=0, period_tick=0.
- Timer, period!=0:
  - cnt counts 0..period-1 and wraps to 0.
  - period_tick=1 when cnt==period-1.
- Timer, period==0:
  - pwm is off.
  - cnt held at 0; period_tick=1 every cycle, so every cycle is a boundary.
- All output registers are registered; changes made on a tick cycle are visible the next cycle, coincident with cnt=0.
- FSM states: IDLE, WAIT_EDGE, RAMP.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&&cmd_ready, capture:
    - np = cmd_period;
    - tgt = min(cmd_duty, cmd_period), i.e. clamped;
    - step = cmd_step; hold = cmd_hold.
  - Then go to WAIT_EDGE. cmd_ready and busy reflect the new state next cycle.
  - abort has no effect in IDLE.
- WAIT_EDGE:
  - On period_tick: period<=np; cnt<=0; duty_cycle<=min(duty_cycle, np); hold_cnt<=0; go to RAMP.
  - If abort is asserted the same cycle as that tick, the period commit still occurs and the state goes to IDLE.
- RAMP:
  - A step is due on a period_tick where hold_cnt==hold.
  - On a tick where hold_cnt!=hold: hold_cnt++.
  - On a due step:
    - if step==0 or |tgt-duty_cycle|<=step: duty_cycle<=tgt, done pulse next cycle, go to IDLE;
    - else duty_cycle<=duty_cycle±step (direction by sign of tgt-duty_cycle); hold_cnt<=0.
  - If duty_cycle==tgt on entry, the first tick still counts as a step and completes with done.
- Arithmetic:
  - Compare unsigned.
  - Difference computed in WIDTH+1 bits.
  - Step zero-extended to WIDTH.
  - No wrap: the clamp rule above guarantees duty stays in 0..period.
- abort in WAIT_EDGE or RAMP:
  - Next cycle state=IDLE; duty_cycle and period frozen at current values.
  - No done pulse.
  - If abort and a due step occur in the same cycle, abort wins: duty is not updated.
- busy=1 in WAIT_EDGE and RAMP.
- done is asserted only for the cycle after completion.
- Command fields are sampled only at acceptance; later changes to cmd_* are ignored.
- Latency:
  - Period commit happens at the first boundary after acceptance.
  - Ramp of N steps takes N·(hold+1) periods after commit.

Decomposition:
- Package pwm_ctrl_pkg:
  - state enum {IDLE, WAIT_EDGE, RAMP};
  - default WIDTH/STEP_W/HOLD_W constants;
  - min/absdiff functions.
- Sub-module pwm_period_timer (clk, rst_n, period → cnt, period_tick).
  - The same counting rule as pwm, so the two stay aligned when both reset together.
- FSM and duty arithmetic live in pwm_ramp_ctrl.

Test Plan:
- Reset → period=0, duty_cycle=0, cmd_ready=1, busy=0, done=0. Assert rst_n low mid-RAMP → all outputs return to reset values in the same cycle.
- From reset, cmd period=10, duty=5, step=0, hold=0 → period=10 and duty_cycle=0 on the next cycle (period 0 makes every cycle a boundary). First tick 10 cycles later → duty_cycle=5, done pulse, cmd_ready=1.
- period=10, duty 0, cmd duty=9 step=4 hold=1 → duty goes 0→4→8→9, changing every 2nd tick (every 20 cycles); done pulses once, after the 9.
- period=100, duty=80, cmd period=50 duty=70 → at the boundary period=50 and duty_cycle clamps to 50 (target 70 clamped to 50); then done.
- Ramp 0→200 step=10 hold=0; assert abort after the 3rd step → duty_cycle frozen at 30, state IDLE, no done. A new command is accepted the following cycle.
- cmd_valid held high while busy → cmd_ready=0 and no capture. Change cmd_duty mid-ramp → no effect on the running target.
